// File: rtl/controlador_instrucao_if.sv
// Bus between the instruction controller and its surroundings: raw buttons,
// the switch instruction word, and everything driven toward the register bank
// and ALU. The controller owns the slave modport.
//
// Strobe protocol: there is no ready path. banco_rw and erro are one-cycle
// pulses that the consumer must sample on the clock edge where they are high.
// busy is high for the whole execute sequence, and estado exposes the FSM state
// for debug.
interface controlador_instrucao_if;
    logic        key_exec_n;
    logic        key_read_n;
    logic [15:0] instr;
    logic [3:0]  codop;
    logic [4:0]  end_reg_a;
    logic [4:0]  end_reg_b;
    logic [4:0]  end_reg_c;
    logic [15:0] imediato;
    logic        flag_imediato;
    logic        banco_rw;
    logic        busy;
    logic        erro;
    logic [7:0]  num_instr;
    logic [1:0]  estado;

    modport slave (
        input  key_exec_n, key_read_n, instr,
        output codop, end_reg_a, end_reg_b, end_reg_c, imediato,
               flag_imediato, banco_rw, busy, erro, num_instr, estado
    );

    modport master (
        output key_exec_n, key_read_n, instr,
        input  codop, end_reg_a, end_reg_b, end_reg_c, imediato,
               flag_imediato, banco_rw, busy, erro, num_instr, estado
    );
endinterface

// File: rtl/controlador_instrucao.sv
// Issue/decode stage: debounces the execute/read buttons, decodes the switch
// instruction word and sequences a single bank write once the ALU result is
// valid.
module controlador_instrucao #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int ALU_LATENCY     = 1
) (
    input  logic clk,
    input  logic rst_n,
    controlador_instrucao_if.slave bus
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DECODE = 2'd1;
    localparam logic [1:0] ST_EXEC   = 2'd2;
    localparam logic [1:0] ST_WRITE  = 2'd3;

    // Index 0 is the execute key, index 1 the read key.
    logic [1:0]    sync1, sync2;
    logic [1:0]    acc, acc_d;
    logic [CW-1:0] deb_cnt [2];
    logic [1:0]    cmd;
    logic          cmd_exec, cmd_read;

    logic [1:0]  state;
    logic [2:0]  wait_cnt;
    logic [3:0]  codop_q;
    logic [4:0]  reg_a_q, reg_b_q, reg_c_q;
    logic [15:0] imm_q;
    logic        flag_q;
    logic        erro_q;
    logic [7:0]  num_q;

    logic [3:0]  op_in;
    logic        op_legal, op_itype;

    // Two-flop synchronizers for the asynchronous button inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 2'b11;
            sync2 <= 2'b11;
        end else begin
            sync1 <= {bus.key_read_n, bus.key_exec_n};
            sync2 <= sync1;
        end
    end

    // Debouncer: accept a new level only after DEBOUNCE_CYCLES consecutive
    // differing samples; any sample equal to the accepted level restarts it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= 2'b11;
            acc_d <= 2'b11;
            for (int k = 0; k < 2; k++) deb_cnt[k] <= '0;
        end else begin
            acc_d <= acc;
            for (int k = 0; k < 2; k++) begin
                if (sync2[k] == acc[k]) begin
                    deb_cnt[k] <= '0;
                end else if (deb_cnt[k] == CW'(DEBOUNCE_CYCLES - 1)) begin
                    acc[k]     <= sync2[k];
                    deb_cnt[k] <= '0;
                end else begin
                    deb_cnt[k] <= deb_cnt[k] + CW'(1);
                end
            end
        end
    end

    // One-cycle command on each falling edge of the accepted (active-low) level.
    assign cmd      = acc_d & ~acc;
    assign cmd_exec = cmd[0];
    assign cmd_read = cmd[1];

    assign op_in    = bus.instr[15:12];
    assign op_legal = (op_in <= 4'd10);
    assign op_itype = (op_in >= 4'd6);

    // Main sequencer. Fields are captured on the edge that enters DECODE so
    // they are already valid during the DECODE cycle; an illegal opcode only
    // raises erro and returns to IDLE without touching the fields.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
            codop_q  <= '0;
            reg_a_q  <= '0;
            reg_b_q  <= '0;
            reg_c_q  <= '0;
            imm_q    <= '0;
            flag_q   <= 1'b0;
            erro_q   <= 1'b0;
            num_q    <= '0;
        end else begin
            erro_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cmd_exec) begin
                        state <= ST_DECODE;
                        if (!op_legal) begin
                            erro_q <= 1'b1;
                        end else if (op_itype) begin
                            codop_q <= op_in;
                            reg_c_q <= {1'b0, bus.instr[11:8]};
                            imm_q   <= {12'd0, bus.instr[7:4]};
                            reg_b_q <= {1'b0, bus.instr[3:0]};
                            reg_a_q <= '0;
                            flag_q  <= 1'b1;
                        end else begin
                            codop_q <= op_in;
                            reg_c_q <= {1'b0, bus.instr[11:8]};
                            reg_a_q <= {1'b0, bus.instr[7:4]};
                            reg_b_q <= {1'b0, bus.instr[3:0]};
                            flag_q  <= 1'b0;
                        end
                    end else if (cmd_read) begin
                        // Display read: point both read ports at the switch fields.
                        reg_a_q <= {1'b0, bus.instr[11:8]};
                        reg_b_q <= {1'b0, bus.instr[7:4]};
                        flag_q  <= 1'b0;
                    end
                end
                ST_DECODE: begin
                    // erro is still high here exactly when the opcode was illegal.
                    if (erro_q) begin
                        state <= ST_IDLE;
                    end else begin
                        state    <= ST_EXEC;
                        wait_cnt <= 3'(ALU_LATENCY);
                    end
                end
                ST_EXEC: begin
                    // Stay ALU_LATENCY cycles, leaving as the count reaches zero.
                    wait_cnt <= wait_cnt - 3'd1;
                    if (wait_cnt == 3'd1) state <= ST_WRITE;
                end
                ST_WRITE: begin
                    num_q <= num_q + 8'd1;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.codop         = codop_q;
    assign bus.end_reg_a     = reg_a_q;
    assign bus.end_reg_b     = reg_b_q;
    assign bus.end_reg_c     = reg_c_q;
    assign bus.imediato      = imm_q;
    assign bus.flag_imediato = flag_q;
    assign bus.banco_rw      = (state == ST_WRITE);
    assign bus.busy          = (state != ST_IDLE);
    assign bus.erro          = erro_q;
    assign bus.num_instr     = num_q;
    assign bus.estado        = state;

endmodule
